// File: rtl/div_fx_hs.sv
// Iterative restoring fixed-point divider: q = (x << FBITS) / y in Q(WIDTH-FBITS).FBITS.
// Resolves STEPS quotient bits per cycle, with valid/ready handshakes and an abort input.
module div_fx_hs #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8,
  parameter int STEPS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_abort,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int ITER = WIDTH + FBITS;
  localparam int N    = ITER / STEPS;
  localparam int CW   = $clog2(N + 1);

  if ((ITER % STEPS) != 0) begin : g_bad_steps
    $error("div_fx_hs: (WIDTH+FBITS) must be a multiple of STEPS");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("div_fx_hs: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Quotient magnitude limits, widened to ITER+1 bits for a direct compare.
  localparam logic [ITER:0] LIM_U  = {{(FBITS + 1){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [ITER:0] LIM_SP = {{(FBITS + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [ITER:0] LIM_SN = {{(FBITS + 1){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] m;
    if (neg) begin
      m = ~v + {{(WIDTH - 1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // One restoring step on the {acc, qreg} pair; returns the updated pair.
  function automatic logic [WIDTH+ITER:0] div_step(input logic [WIDTH:0]   acc,
                                                   input logic [ITER-1:0]  q,
                                                   input logic [WIDTH-1:0] y);
    logic [WIDTH:0]  a;
    logic [ITER-1:0] qq;
    a  = {acc[WIDTH-1:0], q[ITER-1]};
    qq = {q[ITER-2:0], 1'b0};
    if (a >= {1'b0, y}) begin
      a     = a - {1'b0, y};
      qq[0] = 1'b1;
    end else begin
      qq[0] = 1'b0;
    end
    return {a, qq};
  endfunction

  state_t           state_r, state_nxt_s;
  logic             signed_r, signed_nxt_s;
  logic             sx_r, sx_nxt_s;
  logic             sy_r, sy_nxt_s;
  logic             dbz_pend_r, dbz_pend_nxt_s;
  logic [WIDTH-1:0] ymag_r, ymag_nxt_s;
  logic [WIDTH:0]   acc_r, acc_nxt_s;
  logic [ITER-1:0]  qreg_r, qreg_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             ready_r, ready_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [WIDTH-1:0] r_r, r_nxt_s;
  logic             dbz_r, dbz_nxt_s;
  logic             ovf_r, ovf_nxt_s;

  logic             neg_s;
  logic             ovf_s;
  logic [ITER:0]    q_ext_s;
  logic             sx_in_s, sy_in_s;
  logic [WIDTH-1:0] xmag_in_s;
  logic [WIDTH:0]   acc_v;
  logic [ITER-1:0]  q_v;

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_q     = q_r;
  assign o_r     = r_r;
  assign o_dbz   = dbz_r;
  assign o_ovf   = ovf_r;

  // Sign handling and range check of the finished quotient magnitude.
  always_comb begin
    neg_s     = signed_r & (sx_r ^ sy_r);
    q_ext_s   = {1'b0, qreg_r};
    sx_in_s   = i_signed & i_x[WIDTH-1];
    sy_in_s   = i_signed & i_y[WIDTH-1];
    xmag_in_s = mag(i_x, sx_in_s);
    if (!signed_r) begin
      ovf_s = (q_ext_s > LIM_U);
    end else if (!neg_s) begin
      ovf_s = (q_ext_s > LIM_SP);
    end else begin
      ovf_s = (q_ext_s > LIM_SN);
    end
  end

  // Next-state and datapath update for the whole divider.
  always_comb begin
    state_nxt_s    = state_r;
    signed_nxt_s   = signed_r;
    sx_nxt_s       = sx_r;
    sy_nxt_s       = sy_r;
    dbz_pend_nxt_s = dbz_pend_r;
    ymag_nxt_s     = ymag_r;
    acc_nxt_s      = acc_r;
    qreg_nxt_s     = qreg_r;
    cnt_nxt_s      = cnt_r;
    q_nxt_s        = q_r;
    r_nxt_s        = r_r;
    dbz_nxt_s      = dbz_r;
    ovf_nxt_s      = ovf_r;
    acc_v          = acc_r;
    q_v            = qreg_r;

    if (i_abort && (state_r != ST_IDLE)) begin
      state_nxt_s    = ST_IDLE;
      dbz_pend_nxt_s = 1'b0;
      acc_nxt_s      = '0;
      qreg_nxt_s     = '0;
      cnt_nxt_s      = '0;
      q_nxt_s        = '0;
      r_nxt_s        = '0;
      dbz_nxt_s      = 1'b0;
      ovf_nxt_s      = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            signed_nxt_s = i_signed;
            sx_nxt_s     = sx_in_s;
            sy_nxt_s     = sy_in_s;
            ymag_nxt_s   = mag(i_y, sy_in_s);
            acc_nxt_s    = '0;
            cnt_nxt_s    = '0;
            if (i_y == {WIDTH{1'b0}}) begin
              // Divide by zero skips the iterations but still passes through FIX.
              dbz_pend_nxt_s = 1'b1;
              qreg_nxt_s     = '0;
              state_nxt_s    = ST_FIX;
            end else begin
              dbz_pend_nxt_s = 1'b0;
              qreg_nxt_s     = ITER'(xmag_in_s) << FBITS;
              state_nxt_s    = ST_CALC;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          for (int i = 0; i < STEPS; i++) begin
            {acc_v, q_v} = div_step(acc_v, q_v, ymag_r);
          end
          acc_nxt_s  = acc_v;
          qreg_nxt_s = q_v;
          cnt_nxt_s  = cnt_r + CW'(1);
          if (cnt_r == CW'(N - 1)) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
        ST_FIX: begin
          state_nxt_s = ST_DONE;
          if (dbz_pend_r) begin
            dbz_nxt_s = 1'b1;
            ovf_nxt_s = 1'b0;
            q_nxt_s   = '0;
            r_nxt_s   = '0;
          end else if (ovf_s) begin
            dbz_nxt_s = 1'b0;
            ovf_nxt_s = 1'b1;
            q_nxt_s   = '0;
            r_nxt_s   = '0;
          end else begin
            dbz_nxt_s = 1'b0;
            ovf_nxt_s = 1'b0;
            q_nxt_s   = mag(qreg_r[WIDTH-1:0], neg_s);
            r_nxt_s   = mag(acc_r[WIDTH-1:0], signed_r & sx_r);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_nxt_s    = ST_IDLE;
            dbz_pend_nxt_s = 1'b0;
            q_nxt_s        = '0;
            r_nxt_s        = '0;
            dbz_nxt_s      = 1'b0;
            ovf_nxt_s      = 1'b0;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end

    ready_nxt_s = (state_nxt_s == ST_IDLE);
    valid_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      signed_r   <= 1'b0;
      sx_r       <= 1'b0;
      sy_r       <= 1'b0;
      dbz_pend_r <= 1'b0;
      ymag_r     <= '0;
      acc_r      <= '0;
      qreg_r     <= '0;
      cnt_r      <= '0;
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      q_r        <= '0;
      r_r        <= '0;
      dbz_r      <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      signed_r   <= signed_nxt_s;
      sx_r       <= sx_nxt_s;
      sy_r       <= sy_nxt_s;
      dbz_pend_r <= dbz_pend_nxt_s;
      ymag_r     <= ymag_nxt_s;
      acc_r      <= acc_nxt_s;
      qreg_r     <= qreg_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ready_r    <= ready_nxt_s;
      valid_r    <= valid_nxt_s;
      q_r        <= q_nxt_s;
      r_r        <= r_nxt_s;
      dbz_r      <= dbz_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_div_fx_hs.sv
// Directed bench for div_fx_hs: WIDTH=8, FBITS=4 with STEPS=1 (main) and STEPS=3 (second instance).
module tb_div_fx_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid1 = 1'b0, valid3 = 1'b0;
  logic       sgn = 1'b0;
  logic [7:0] x = 8'h00, y = 8'h00;
  logic       abort = 1'b0;
  logic       rdy = 1'b0;

  logic       ready_o1, valid_o1, dbz1, ovf1;
  logic [7:0] q1, r1;
  logic       ready_o3, valid_o3, dbz3, ovf3;
  logic [7:0] q3, r3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_fx_hs #(.WIDTH(8), .FBITS(4), .STEPS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .o_ready(ready_o1),
    .i_signed(sgn), .i_x(x), .i_y(y), .i_abort(abort), .o_valid(valid_o1),
    .i_ready(rdy), .o_q(q1), .o_r(r1), .o_dbz(dbz1), .o_ovf(ovf1)
  );

  div_fx_hs #(.WIDTH(8), .FBITS(4), .STEPS(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid3), .o_ready(ready_o3),
    .i_signed(sgn), .i_x(x), .i_y(y), .i_abort(abort), .o_valid(valid_o3),
    .i_ready(rdy), .o_q(q3), .o_r(r3), .o_dbz(dbz3), .o_ovf(ovf3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, result, hold behaviour and the release handshake.
  task automatic run_op(input string tag, input bit sel3, input logic s, input logic [7:0] xv,
                        input logic [7:0] yv, input int exp_lat, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input logic eovf, input int hold);
    int lat;
    @(negedge clk);
    check({tag, ".ready"}, sel3 ? ready_o3 : ready_o1, 1);
    sgn = s; x = xv; y = yv;
    if (sel3) valid3 = 1'b1; else valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0; valid3 = 1'b0;
    x = ~xv; y = 8'h00; sgn = ~s;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(sel3 ? valid_o3 : valid_o1) && lat < 40);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".q"}, sel3 ? q3 : q1, eq);
    check({tag, ".r"}, sel3 ? r3 : r1, er);
    check({tag, ".dbz"}, sel3 ? dbz3 : dbz1, edbz);
    check({tag, ".ovf"}, sel3 ? ovf3 : ovf1, eovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, sel3 ? valid_o3 : valid_o1, 1);
      check({tag, ".hold_ready"}, sel3 ? ready_o3 : ready_o1, 0);
      check({tag, ".hold_q"}, sel3 ? q3 : q1, eq);
      check({tag, ".hold_r"}, sel3 ? r3 : r1, er);
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    check({tag, ".rel_valid"}, sel3 ? valid_o3 : valid_o1, 0);
    check({tag, ".rel_ready"}, sel3 ? ready_o3 : ready_o1, 1);
    check({tag, ".rel_dbz"}, sel3 ? dbz3 : dbz1, 0);
  endtask

  initial begin
    bit saw_valid;
    #12;
    check("rst.ready", ready_o1, 1);
    check("rst.valid", valid_o1, 0);
    check("rst.q", q1, 0);
    check("rst.r", r1, 0);
    check("rst.flags", {dbz1, ovf1}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("u13_4",    1'b0, 1'b0, 8'h0D, 8'h04, 13, 8'h34, 8'h00, 1'b0, 1'b0, 0);
    run_op("s-7_3",    1'b0, 1'b1, 8'hF9, 8'h03, 13, 8'hDB, 8'hFF, 1'b0, 1'b0, 0);
    run_op("s7_-3",    1'b0, 1'b1, 8'h07, 8'hFD, 13, 8'hDB, 8'h01, 1'b0, 1'b0, 0);
    run_op("s-128_1",  1'b0, 1'b1, 8'h80, 8'h10, 13, 8'h80, 8'h00, 1'b0, 1'b0, 0);
    run_op("s-128_-1", 1'b0, 1'b1, 8'h80, 8'hF0, 13, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    run_op("u255_1",   1'b0, 1'b0, 8'hFF, 8'h10, 13, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
    run_op("u_ovf",    1'b0, 1'b0, 8'h80, 8'h01, 13, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    run_op("s_ovf",    1'b0, 1'b1, 8'h40, 8'h01, 13, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    run_op("u_dbz",    1'b0, 1'b0, 8'h55, 8'h00, 1,  8'h00, 8'h00, 1'b1, 1'b0, 0);
    run_op("after_dbz",1'b0, 1'b0, 8'h0D, 8'h04, 13, 8'h34, 8'h00, 1'b0, 1'b0, 0);
    run_op("s_dbz",    1'b0, 1'b1, 8'h80, 8'h00, 1,  8'h00, 8'h00, 1'b1, 1'b0, 0);
    run_op("hold5",    1'b0, 1'b0, 8'h0D, 8'h04, 13, 8'h34, 8'h00, 1'b0, 1'b0, 5);
    run_op("steps3",   1'b1, 1'b0, 8'h0D, 8'h04, 5,  8'h34, 8'h00, 1'b0, 1'b0, 0);

    // Abort five cycles after accept.
    @(negedge clk);
    sgn = 1'b0; x = 8'h0D; y = 8'h04; valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort.ready", ready_o1, 1);
    check("abort.valid", valid_o1, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valid_o1) saw_valid = 1'b1;
    end
    check("abort.no_valid", saw_valid, 0);
    run_op("after_abort", 1'b0, 1'b1, 8'hF9, 8'h03, 13, 8'hDB, 8'hFF, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    sgn = 1'b0; x = 8'h0D; y = 8'h04; valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst.ready", ready_o1, 1);
    check("mrst.valid", valid_o1, 0);
    check("mrst.q", q1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valid_o1) saw_valid = 1'b1;
    end
    check("mrst.no_valid", saw_valid, 0);
    run_op("after_rst", 1'b0, 1'b0, 8'h0D, 8'h04, 13, 8'h34, 8'h00, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
